backprop_update: RTL and testbench

Backward-pass companion to the sigmoid activation stage of the two-input neuron. It takes the activation output, the target class, the inputs, the current weights, the bias and the learning rate, and computes the error delta. From the delta it produces updated weights and bias using one shared multiplier sequenced by an FSM. Upstream and downstream connections use valid/ready handshakes, so the block sits between the activation stage and the weight registers.

---
 rtl/backprop_update.sv | 144 ++++++++++++++
 tb/tb_backprop_update.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/backprop_update.sv
// rtl/backprop_update.sv - Q4.12 error-delta and parameter update for the two-input sigmoid neuron
// One shared saturating multiplier, sequenced by a nine-state FSM between valid/ready handshakes.
module backprop_update #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] y,
   input  logic         target,
   input  logic [W-1:0] x0,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] w0,
   input  logic [W-1:0] w1,
   input  logic [W-1:0] bias,
   input  logic [W-1:0] lr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] w0_new,
   output logic [W-1:0] w1_new,
   output logic [W-1:0] bias_new,
   output logic [W-1:0] delta,
   output logic         hit
);

   localparam int FRAC = 12;
   localparam logic [W-1:0] ONE  = W'(1 << FRAC);
   localparam logic [W-1:0] HALF = W'(1 << (FRAC - 1));
   localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [3:0] {
      S_IDLE, S_ERR, S_DER, S_DEL, S_GRD, S_UW0, S_UW1, S_UB, S_DONE
   } state_t;

   state_t r_state, w_next;

   logic [W-1:0] r_y, r_x0, r_x1, r_w0, r_w1, r_bias, r_lr;
   logic         r_target;
   logic [W-1:0] r_err, r_d, r_g;
   logic [W-1:0] r_delta, r_w0_new, r_w1_new, r_bias_new;
   logic         r_hit;
   logic [W-1:0] w_mul_a, w_mul_b, w_mul_p, w_y_clamped;

   function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {a[W-1], a} + {b[W-1], b};
      if (s[W] != s[W-1]) return s[W] ? MINV : MAXV;
      return s[W-1:0];
   endfunction

   // Full-width product, arithmetic shift (floor), then saturate to W bits.
   function automatic logic [W-1:0] sat_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] sa, sb, p;
      sa = $signed({{W{a[W-1]}}, a});
      sb = $signed({{W{b[W-1]}}, b});
      p  = (sa * sb) >>> FRAC;
      if ((&p[2*W-1:W-1]) || !(|p[2*W-1:W-1])) return p[W-1:0];
      return p[2*W-1] ? MINV : MAXV;
   endfunction

   always_comb begin
      w_y_clamped = y;
      if (y[W-1])                    w_y_clamped = '0;
      else if ($signed(y) > $signed(ONE)) w_y_clamped = ONE;
   end

   always_comb begin
      w_mul_a = '0;
      w_mul_b = '0;
      case (r_state)
         S_DER:   begin w_mul_a = r_y;   w_mul_b = sat_add(ONE, ~r_y + 1'b1); end
         S_DEL:   begin w_mul_a = r_err; w_mul_b = r_d;     end
         S_GRD:   begin w_mul_a = r_lr;  w_mul_b = r_delta; end
         S_UW0:   begin w_mul_a = r_g;   w_mul_b = r_x0;    end
         S_UW1:   begin w_mul_a = r_g;   w_mul_b = r_x1;    end
         default: begin w_mul_a = '0;    w_mul_b = '0;      end
      endcase
   end

   assign w_mul_p = sat_mul(w_mul_a, w_mul_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = S_ERR;
         S_ERR:   w_next = S_DER;
         S_DER:   w_next = S_DEL;
         S_DEL:   w_next = S_GRD;
         S_GRD:   w_next = S_UW0;
         S_UW0:   w_next = S_UW1;
         S_UW1:   w_next = S_UB;
         S_UB:    w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == S_IDLE);
      out_valid = (r_state == S_DONE);
      delta     = r_delta;
      w0_new    = r_w0_new;
      w1_new    = r_w1_new;
      bias_new  = r_bias_new;
      hit       = r_hit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y <= '0; r_x0 <= '0; r_x1 <= '0; r_w0 <= '0; r_w1 <= '0;
         r_bias <= '0; r_lr <= '0; r_target <= 1'b0;
         r_err <= '0; r_d <= '0; r_g <= '0;
         r_delta <= '0; r_w0_new <= '0; r_w1_new <= '0; r_bias_new <= '0;
         r_hit <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid) begin
               r_y <= w_y_clamped; r_target <= target;
               r_x0 <= x0; r_x1 <= x1; r_w0 <= w0; r_w1 <= w1;
               r_bias <= bias; r_lr <= lr;
            end
            S_ERR: begin
               r_err <= sat_add(r_target ? ONE : '0, ~r_y + 1'b1);
               r_hit <= ((r_y >= HALF) == r_target);
            end
            S_DER:   r_d        <= w_mul_p;
            S_DEL:   r_delta    <= w_mul_p;
            S_GRD:   r_g        <= w_mul_p;
            S_UW0:   r_w0_new   <= sat_add(r_w0, w_mul_p);
            S_UW1:   r_w1_new   <= sat_add(r_w1, w_mul_p);
            S_UB:    r_bias_new <= sat_add(r_bias, r_g);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_backprop_update.sv
// tb/tb_backprop_update.sv - table-driven directed checks for backprop_update
// Covers arithmetic vectors, latency, backpressure with busy in_valid, and mid-run reset.
module tb_backprop_update;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, target, out_valid, out_ready, hit;
   logic [W-1:0] y, x0, x1, w0, w1, bias, lr;
   logic [W-1:0] w0_new, w1_new, bias_new, delta;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [W-1:0] y;
      logic         target;
      logic [W-1:0] x0, x1, w0, w1, bias, lr;
      logic [W-1:0] e_delta, e_w0, e_w1, e_bias;
      logic         e_hit;
   } vec_t;

   vec_t vecs[6];

   backprop_update #(.W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .target(target), .x0(x0), .x1(x1),
      .w0(w0), .w1(w1), .bias(bias), .lr(lr),
      .out_valid(out_valid), .out_ready(out_ready),
      .w0_new(w0_new), .w1_new(w1_new), .bias_new(bias_new),
      .delta(delta), .hit(hit)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      y = v.y; target = v.target; x0 = v.x0; x1 = v.x1;
      w0 = v.w0; w1 = v.w1; bias = v.bias; lr = v.lr;
   endtask

   task automatic scramble();
      y = 16'($urandom); target = 1'($urandom); x0 = 16'($urandom); x1 = 16'($urandom);
      w0 = 16'($urandom); w1 = 16'($urandom); bias = 16'($urandom); lr = 16'($urandom);
   endtask

   task automatic check_results(input vec_t v, input string tag);
      check({tag, ".delta"},    32'(delta),    32'(v.e_delta));
      check({tag, ".w0_new"},   32'(w0_new),   32'(v.e_w0));
      check({tag, ".w1_new"},   32'(w1_new),   32'(v.e_w1));
      check({tag, ".bias_new"}, 32'(bias_new), 32'(v.e_bias));
      check({tag, ".hit"},      32'(hit),      32'(v.e_hit));
   endtask

   // Latency counts rising edges including the capture edge until out_valid is seen.
   task automatic run_txn(input vec_t v, input string tag);
      int lat;
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      out_ready = 1'b1;
      check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      scramble();
      while (!out_valid && lat < 30) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, ".latency"}, 32'(lat), 32'd8);
      check_results(v, tag);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".in_ready_after"},  32'(in_ready),  32'd1);
      check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
      check({tag, ".delta_held"},      32'(delta),     32'(v.e_delta));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wait_cnt;
      //            y        tg  x0       x1       w0       w1       bias     lr       delta    w0n      w1n      bn       hit
      vecs[0] = '{16'h0800, 1, 16'h1000, 16'h2000, 16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0200, 16'h0200, 16'h1400, 16'h0200, 1};
      vecs[1] = '{16'h0C00, 0, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'hFDC0, 16'hFDC0, 16'h0000, 16'hFDC0, 0};
      vecs[2] = '{16'h0800, 1, 16'h7FFF, 16'h0000, 16'h7F00, 16'h0000, 16'h0000, 16'h7FFF, 16'h0200, 16'h7FFF, 16'h0000, 16'h0FFF, 1};
      vecs[3] = '{16'h1800, 0, 16'h1000, 16'h1000, 16'h1234, 16'h0100, 16'h0010, 16'h1000, 16'h0000, 16'h1234, 16'h0100, 16'h0010, 0};
      vecs[4] = '{16'hF000, 1, 16'h1000, 16'h1000, 16'h0055, 16'h0066, 16'h0077, 16'h1000, 16'h0000, 16'h0055, 16'h0066, 16'h0077, 0};
      vecs[5] = '{16'h0400, 0, 16'hF000, 16'h3000, 16'h0000, 16'h0000, 16'h0100, 16'h0801, 16'hFF40, 16'h0061, 16'hFEDD, 16'h009F, 1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      y = '0; target = 1'b0; x0 = '0; x1 = '0; w0 = '0; w1 = '0; bias = '0; lr = '0;
      repeat (2) @(negedge clk);
      check("reset.in_ready",  32'(in_ready),  32'd1);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check_results('{16'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0}, "reset");
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: out_ready low, in_valid held with different data throughout.
      @(negedge clk);
      drive(vecs[0]);
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      drive(vecs[1]);
      wait_cnt = 0;
      while (!out_valid && wait_cnt < 30) begin
         @(posedge clk);
         wait_cnt++;
         @(negedge clk);
      end
      check("bp.reached_done", 32'(out_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp.hold%0d.out_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("bp.hold%0d.in_ready", c),  32'(in_ready),  32'd0);
         check($sformatf("bp.hold%0d.delta", c),     32'(delta),     32'h0200);
         check($sformatf("bp.hold%0d.w1_new", c),    32'(w1_new),    32'h1400);
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp.release.in_ready",  32'(in_ready),  32'd1);
      check("bp.release.out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp.second_capture.in_ready", 32'(in_ready), 32'd0);
      wait_cnt = 0;
      while (!out_valid && wait_cnt < 30) begin
         @(posedge clk);
         wait_cnt++;
         @(negedge clk);
      end
      check_results(vecs[1], "bp.second");
      @(posedge clk);

      // Reset during DEL must abort and clear everything immediately.
      @(negedge clk);
      drive(vecs[0]);
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid.in_ready",  32'(in_ready),  32'd1);
      check("rst_mid.out_valid", 32'(out_valid), 32'd0);
      check_results('{16'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0}, "rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(vecs[0], "after_reset");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
